// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared types and constants for the multiplier-sharing arbiter
package mul_share_pkg;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int MUL_W  = 8;
  localparam int PROD_W = 16;

  // Tag width for a requester count; a single requester still needs one bit.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arb_rr_arbiter.sv
// rtl/mul_share_arb_rr_arbiter.sv - round-robin one-hot grant with registered pointer
module mul_share_arb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [TAG_W-1:0]   o_idx,
  output logic               o_hs
);

  logic [TAG_W-1:0] r_ptr;

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_hs    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_hs && i_en && i_req[j]) begin
        o_hs       = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = TAG_W'(j);
      end
    end
  end

  // Grants only go to valid requesters, so a grant is always a handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (o_hs) begin
      if (int'(o_idx) == NUM_REQ - 1) r_ptr <= '0;
      else                            r_ptr <= o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - shares one pipelined 8x8 multiplier among requesters with tag routing and flush
// Optional busy/stall counters are built when MUL_SHARE_ARB_PERF_EN is defined.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MUL_W-1:0]     req_a,
  input  logic [NUM_REQ*MUL_W-1:0]     req_b,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [PROD_W-1:0]            rsp_data,
  output logic                         mul_en_in,
  output logic [MUL_W-1:0]             mul_a,
  output logic [MUL_W-1:0]             mul_b,
  input  logic                         mul_en_out,
  input  logic [PROD_W-1:0]            mul_out,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(MUL_LAT+1)-1:0] inflight,
  output logic                         tag_err
`ifdef MUL_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]                  busy_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int TAG_W = tag_w(NUM_REQ);
  localparam int CNT_W = $clog2(MUL_LAT + 1);
  typedef logic [TAG_W-1:0] tag_t;

  state_t             r_state;
  tag_t               r_issue_tag;
  logic [MUL_LAT-1:0] r_pv;
  tag_t               r_ptag [MUL_LAT];
  logic [CNT_W-1:0]   r_quiet;
  tag_t               w_idx;
  logic               w_hs;
  logic               w_tail_v;
  logic               w_ret;
  logic               w_err;

  mul_share_arb_rr_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    ((r_state == S_RUN) && !rst),
    .i_req   (req_valid),
    .o_grant (req_ready),
    .o_idx   (w_idx),
    .o_hs    (w_hs)
  );

  assign w_tail_v = r_pv[MUL_LAT-1];
  assign w_ret    = mul_en_out && w_tail_v;
  // Results from operations issued before a reset can still trickle out for
  // MUL_LAT cycles; they are neither routed nor treated as protocol errors.
  assign w_err    = (mul_en_out != w_tail_v) && (r_quiet == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_en_in   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      r_issue_tag <= '0;
    end else begin
      mul_en_in <= w_hs;
      if (w_hs) begin
        mul_a       <= req_a[MUL_W*w_idx +: MUL_W];
        mul_b       <= req_b[MUL_W*w_idx +: MUL_W];
        r_issue_tag <= w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_ptag[i] <= '0;
    end else begin
      r_pv[0]   <= mul_en_in;
      r_ptag[0] <= r_issue_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_ptag[i] <= r_ptag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      tag_err   <= 1'b0;
      inflight  <= '0;
      r_quiet   <= CNT_W'(MUL_LAT);
    end else begin
      rsp_valid <= '0;
      if (w_ret) begin
        rsp_valid[r_ptag[MUL_LAT-1]] <= 1'b1;
        rsp_data                     <= mul_out;
      end
      if (w_err) tag_err <= 1'b1;
      // A tail entry leaves the pipe whether it returned or was dropped.
      if (mul_en_in && !w_tail_v)      inflight <= inflight + 1'b1;
      else if (!mul_en_in && w_tail_v) inflight <= inflight - 1'b1;
      if (r_quiet != '0) r_quiet <= r_quiet - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      flush_done <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (flush_req) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!flush_req) begin
            r_state <= S_RUN;
          end else if (inflight == '0 && !mul_en_in) begin
            r_state    <= S_DONE;
            flush_done <= 1'b1;
          end
        end
        S_DONE: begin
          if (!flush_req) begin
            r_state    <= S_RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_SHARE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (mul_en_in && busy_cnt != '1) busy_cnt <= busy_cnt + 32'd1;
      if ((req_valid != '0) && !w_hs && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - scoreboard bench for mul_share_arb with a behavioural multiplier
module tb_mul_share_arb;

  localparam int NUM_REQ = 4;
  localparam int MUL_LAT = 4;
  localparam int CW      = $clog2(MUL_LAT + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a = '0;
  logic [NUM_REQ*8-1:0] req_b = '0;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic                 mul_en_in;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic                 mul_en_out;
  logic [15:0]          mul_out;
  logic                 flush_req = 1'b0;
  logic                 flush_done;
  logic [CW-1:0]        inflight;
  logic                 tag_err;
`ifdef MUL_SHARE_ARB_PERF_EN
  logic [31:0]          busy_cnt;
  logic [31:0]          stall_cnt;
`endif

  mul_share_arb #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mul_en_in  (mul_en_in),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_en_out (mul_en_out),
    .mul_out    (mul_out),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .inflight   (inflight),
    .tag_err    (tag_err)
`ifdef MUL_SHARE_ARB_PERF_EN
    ,
    .busy_cnt   (busy_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: not reset, so in-flight work survives a DUT reset.
  logic [MUL_LAT-1:0] m_v = '0;
  logic [15:0]        m_p [MUL_LAT];
  logic               spur = 1'b0;
  always @(posedge clk) begin
    m_v[0] <= mul_en_in;
    m_p[0] <= {8'h00, mul_a} * {8'h00, mul_b};
    for (int i = 1; i < MUL_LAT; i++) begin
      m_v[i] <= m_v[i-1];
      m_p[i] <= m_p[i-1];
    end
  end
  assign mul_en_out = m_v[MUL_LAT-1] | spur;
  assign mul_out    = m_p[MUL_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    logic [15:0] prod;
    int          hcyc;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int last_rsp_cyc = -1;

  // Scoreboard: push on every handshake, pop and compare on every response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.idx  = i;
          e.prod = {8'h00, req_a[8*i +: 8]} * {8'h00, req_b[8*i +: 8]};
          e.hcyc = cyc;
          sb.push_back(e);
        end
      end
      if (rsp_valid != '0) begin
        last_rsp_cyc = cyc;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL rsp_unexpected: rsp_valid=%b with no pending op", rsp_valid);
        end else begin
          n_pass++;
          e = sb.pop_front();
          n_chk++;
          if (rsp_valid !== NUM_REQ'(1 << e.idx))
            $display("FAIL rsp_owner: got %b expected %b", rsp_valid, NUM_REQ'(1 << e.idx));
          else n_pass++;
          n_chk++;
          if (rsp_data !== e.prod)
            $display("FAIL rsp_data: got %h expected %h", rsp_data, e.prod);
          else n_pass++;
          n_chk++;
          if (cyc - e.hcyc != MUL_LAT + 2)
            $display("FAIL rsp_latency: got %0d expected %0d", cyc - e.hcyc, MUL_LAT + 2);
          else n_pass++;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; flush_req = 1'b0; spur = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_data, mul_en_in, mul_a, mul_b} !== '0)
      $display("FAIL reset_outputs: rdy=%b rsp=%b data=%h en=%b a=%h b=%h",
               req_ready, rsp_valid, rsp_data, mul_en_in, mul_a, mul_b);
    else n_pass++;
    n_chk++;
    if ({inflight, flush_done, tag_err} !== '0)
      $display("FAIL reset_status: inflight=%0d done=%b err=%b", inflight, flush_done, tag_err);
    else n_pass++;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req_valid = 4'b0100; req_a[23:16] = 8'd13; req_b[23:16] = 8'd11;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_chk++;
    if ({mul_en_in, mul_a, mul_b} !== {1'b1, 8'd13, 8'd11})
      $display("FAIL single_issue: en=%b a=%0d b=%0d expected 1 13 11", mul_en_in, mul_a, mul_b);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (inflight !== CW'(1)) $display("FAIL single_inflight: got %0d expected 1", inflight);
    else n_pass++;
    repeat (MUL_LAT + 4) @(negedge clk);
    n_chk++;
    if (inflight !== '0 || sb.size() != 0)
      $display("FAIL single_drain: inflight=%0d pending=%0d expected 0 0", inflight, sb.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] ta [8];
    logic [7:0] tb [8];
    ta = '{8'd3, 8'd17, 8'hFF, 8'd200, 8'd0, 8'd99, 8'd128, 8'd7};
    tb = '{8'd5, 8'd19, 8'hFF, 8'd2, 8'd77, 8'd101, 8'd128, 8'd255};
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_a[8*r +: 8] = ta[r];
      req_b[8*r +: 8] = tb[r];
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      n_chk++;
      if (req_ready !== NUM_REQ'(1 << (g % NUM_REQ)))
        $display("FAIL rr_order[%0d]: got %b expected %b", g, req_ready, NUM_REQ'(1 << (g % NUM_REQ)));
      else n_pass++;
      @(posedge clk); #1;
      if (g < 4) begin
        req_a[8*g +: 8] = ta[g+4];
        req_b[8*g +: 8] = tb[g+4];
      end
      if (g == 7) req_valid = '0;
    end
    repeat (MUL_LAT + 4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) $display("FAIL rr_drain: pending=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_flush();
    bit saw_ready;
    bit done_seen;
    @(posedge clk); #1;
    req_a = 32'h0906_0403; req_b = 32'h0A07_0502;
    req_valid = 4'b0111;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL flush_g0: got %b expected 0001", req_ready);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL flush_g1: got %b expected 0010", req_ready);
    else n_pass++;
    @(posedge clk); #1 flush_req = 1'b1;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0100) $display("FAIL flush_same_cycle_grant: got %b expected 0100", req_ready);
    else n_pass++;
    @(posedge clk); #1 req_valid = 4'b1111;
    @(negedge clk);
    n_chk++;
    if (req_ready !== '0 || inflight !== CW'(2) || flush_done !== 1'b0)
      $display("FAIL flush_drain_start: rdy=%b inflight=%0d done=%b expected 0000 2 0",
               req_ready, inflight, flush_done);
    else n_pass++;
    saw_ready = 1'b0;
    done_seen = 1'b0;
    for (int k = 0; k < 30 && !done_seen; k++) begin
      @(negedge clk);
      if (req_ready != '0) saw_ready = 1'b1;
      if (flush_done) done_seen = 1'b1;
    end
    n_chk++;
    if (!done_seen || saw_ready)
      $display("FAIL flush_done_seen: done=%b grant_in_drain=%b expected 1 0", done_seen, saw_ready);
    else n_pass++;
    n_chk++;
    if (cyc != last_rsp_cyc + 1 || sb.size() != 0)
      $display("FAIL flush_done_timing: done_cyc=%0d last_rsp=%0d pending=%0d", cyc, last_rsp_cyc, sb.size());
    else n_pass++;
    @(posedge clk); #1 flush_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (req_ready !== '0 || flush_done !== 1'b1)
      $display("FAIL flush_release_lag: rdy=%b done=%b expected 0000 1", req_ready, flush_done);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b1000 || flush_done !== 1'b0)
      $display("FAIL flush_resume_rr: rdy=%b done=%b expected 1000 0", req_ready, flush_done);
    else n_pass++;
    @(posedge clk); #1 req_valid = '0;
    repeat (MUL_LAT + 4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0 || inflight !== '0)
      $display("FAIL flush_final_drain: pending=%0d inflight=%0d", sb.size(), inflight);
    else n_pass++;
  endtask

  task automatic test_tag_err();
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tag_err !== 1'b1 || inflight !== '0)
      $display("FAIL tag_err_set: err=%b inflight=%0d expected 1 0", tag_err, inflight);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++;
    if (tag_err !== 1'b1) $display("FAIL tag_err_sticky: got %b expected 1", tag_err);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (tag_err !== 1'b0) $display("FAIL tag_err_clear: got %b expected 0", tag_err);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    req_a[15:0] = 16'h2211; req_b[15:0] = 16'h4433;
    req_valid = 4'b0011;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0001) $display("FAIL rstfl_g0: got %b expected 0001", req_ready);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (req_ready !== 4'b0010) $display("FAIL rstfl_g1: got %b expected 0010", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, mul_en_in, mul_a, mul_b, inflight, flush_done, tag_err} !== '0)
      $display("FAIL rstfl_outputs: rdy=%b rsp=%b en=%b a=%h b=%h inflight=%0d done=%b err=%b",
               req_ready, rsp_valid, mul_en_in, mul_a, mul_b, inflight, flush_done, tag_err);
    else n_pass++;
    repeat (MUL_LAT + 3) @(negedge clk);
    n_chk++;
    if (tag_err !== 1'b0 || inflight !== '0)
      $display("FAIL rstfl_late_result: err=%b inflight=%0d expected 0 0", tag_err, inflight);
    else n_pass++;
  endtask

`ifdef MUL_SHARE_ARB_PERF_EN
  task automatic test_perf();
    int nhs;
    do_reset();
    req_a = 32'h0403_0201; req_b = 32'h0807_0605;
    req_valid = 4'b1111;
    nhs = 0;
    for (int k = 0; k < 40 && nhs < 10; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) nhs++;
      if (nhs == 10) begin
        @(posedge clk); #1 req_valid = '0;
      end
    end
    repeat (MUL_LAT + 4) @(negedge clk);
    n_chk++;
    if (busy_cnt !== 32'd10) $display("FAIL perf_busy: got %0d expected 10", busy_cnt);
    else n_pass++;
    n_chk++;
    if (stall_cnt !== 32'd0) $display("FAIL perf_stall: got %0d expected 0", stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_tag_err();
    test_reset_inflight();
`ifdef MUL_SHARE_ARB_PERF_EN
    test_perf();
`endif
    repeat (MUL_LAT + 4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) $display("FAIL final_pending: %0d responses never arrived", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
